// File: rtl/fp_mult_sequencer.sv
// fp_mult_sequencer: queues IEEE-754 single-precision operand pairs in a small
// FIFO and issues them one at a time to an external multi-cycle multiplier.
// Each product is captured together with the multiplier flags seen during the
// operation. The result is held in a registered output stage until the
// consumer takes it.
//
// Optional build macro: FPSEQ_TIMEOUT_EN. When it is defined, an operation
// whose multiplier stays silent for 8 WAIT cycles is closed with a quiet-NaN
// product and the timeout flag.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid_i/in_ready_o          operand-pair handshake; a_i, b_i operands
//   mul_start_o                    one-cycle start pulse to the multiplier
//   mul_a_o, mul_b_o               operands, held for the whole operation
//   mul_product_i, mul_done_i      multiplier result and completion pulse
//   mul_{nan,inf,ovf,unf}_i        multiplier flag pulses
//   out_valid_o/out_ready_i        result handshake
//   out_product_o                  result product
//   out_flags_o                    result flags {timeout, nan, inf, ovf, unf}
//   sticky_flags_o                 OR of result flags since the last clear
//   clear_sticky_i                 clears sticky_flags_o
//   busy_o                         FSM active or operands queued
module fp_mult_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        mul_start_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [31:0] mul_product_i,
    input  logic        mul_done_i,
    input  logic        mul_nan_i,
    input  logic        mul_inf_i,
    input  logic        mul_ovf_i,
    input  logic        mul_unf_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_product_o,
    output logic [4:0]  out_flags_o,
    output logic [4:0]  sticky_flags_o,
    input  logic        clear_sticky_i,
    output logic        busy_o
);

    localparam int unsigned FP_W   = 32;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned MFLG_W = 4;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
`ifdef FPSEQ_TIMEOUT_EN
    localparam int unsigned TMO_W    = 4;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(7);
    localparam logic [FP_W-1:0]  QNAN     = 32'h7FC0_0000;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2*FP_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FP_W-1:0]     op_a_q, op_a_d;
    logic [FP_W-1:0]     op_b_q, op_b_d;
    logic                start_q, start_d;
    logic [MFLG_W-1:0]   acc_q, acc_d;
    logic                out_valid_q, out_valid_d;
    logic [FP_W-1:0]     product_q, product_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [FLAG_W-1:0]   sticky_q, sticky_d;
    logic                busy_q, busy_d;
`ifdef FPSEQ_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

    logic                fifo_full;
    logic                fifo_empty;
    logic                out_free;
    logic                push;
    logic                pop;
    logic                load;
    logic [MFLG_W-1:0]   mul_flags;
    logic [2*FP_W-1:0]   head;

    // FIFO status and handshakes; a pop in the same cycle frees a slot, so a
    // full FIFO still accepts a pair while it hands its head to the FSM.
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign out_free   = !out_valid_q || out_ready_i;
    assign pop        = (state_q == S_IDLE) && !fifo_empty && out_free;
    assign in_ready_o = !fifo_full || pop;
    assign push       = in_valid_i && in_ready_o;
    assign mul_flags  = {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
    assign head       = fifo_mem[rd_ptr_q];

    // Operand storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {a_i, b_i};
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer FSM next-state and result/flag datapath.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        start_d     = 1'b0;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready_i;
        product_d   = product_q;
        flags_d     = flags_q;
        load        = 1'b0;
`ifdef FPSEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_ISSUE;
                    op_a_d  = head[2*FP_W-1:FP_W];
                    op_b_d  = head[FP_W-1:0];
                    start_d = 1'b1;
                    acc_d   = '0;
                end
            end
            S_ISSUE: begin
                // Flags may pulse as early as the start cycle.
                acc_d   = acc_q | mul_flags;
                state_d = S_WAIT;
`ifdef FPSEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                acc_d = acc_q | mul_flags;
                if (mul_done_i) begin
                    load      = 1'b1;
                    product_d = mul_product_i;
                    flags_d   = {1'b0, acc_q | mul_flags};
                    state_d   = S_OUTPUT;
                end
`ifdef FPSEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    // Eighth silent WAIT cycle: close with a quiet NaN.
                    load      = 1'b1;
                    product_d = QNAN;
                    flags_d   = {1'b1, acc_q | mul_flags};
                    state_d   = S_OUTPUT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            S_OUTPUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            out_valid_d = 1'b1;
        end

        // A load wins over a coincident clear so its flags are never lost.
        sticky_d = clear_sticky_i ? '0 : sticky_q;
        if (load) begin
            sticky_d = sticky_d | flags_d;
        end

        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            start_q     <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            flags_q     <= '0;
            sticky_q    <= '0;
            busy_q      <= 1'b0;
`ifdef FPSEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            start_q     <= start_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
            busy_q      <= busy_d;
`ifdef FPSEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign mul_start_o    = start_q;
    assign mul_a_o        = op_a_q;
    assign mul_b_o        = op_b_q;
    assign out_valid_o    = out_valid_q;
    assign out_product_o  = product_q;
    assign out_flags_o    = flags_q;
    assign sticky_flags_o = sticky_q;
    assign busy_o         = busy_q;

endmodule
